// File: rtl/ice40_pll_seq_ctrl.sv
// iCE40 PLL40 power-up/lock supervisor: sequences RESETB, qualifies LOCK,
// retries on timeout and falls back to BYPASS after repeated failures.
module ice40_pll_seq_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_STABLE  = 64,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       pll_lock_i,
  input  logic       restart_i,
  output logic       pll_resetb_o,
  output logic       pll_bypass_o,
  output logic       rstn_sys_o,
  output logic       locked_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o,
  output logic [2:0] state_o
);

  localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C  = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
  localparam int CW     = $clog2(MAX_C);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_BYPASS = 3'd4
  } state_e;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retries_q, retries_d;
  logic          sync1_q, lock_s_q;
  logic          resetb_q, resetb_d;
  logic          bypass_q, bypass_d;
  logic          rstn_sys_q, rstn_sys_d;
  logic          locked_q, locked_d;
  logic          fail_q, fail_d;

  // LOCK is asynchronous to the oscillator; only the second flop is used.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock_i;
      lock_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    if (restart_i) begin
      state_d   = ST_RESET;
      cnt_d     = '0;
      retries_d = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_WAIT: begin
          if (lock_s_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retries_d = sat_inc4(retries_q);
            state_d   = (retries_d >= RETRY_LIMIT) ? ST_BYPASS : ST_RESET;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_STABLE: begin
          // A dropout restarts the timeout window without charging a retry.
          if (!lock_s_q) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d   = ST_RUN;
            cnt_d     = '0;
            retries_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!lock_s_q) begin
            state_d = ST_RESET;
            cnt_d   = '0;
          end
        end
        ST_BYPASS: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change with state_q.
  always_comb begin
    resetb_d   = (state_d == ST_WAIT) || (state_d == ST_STABLE) || (state_d == ST_RUN);
    bypass_d   = (state_d == ST_BYPASS);
    rstn_sys_d = (state_d == ST_RUN) || (state_d == ST_BYPASS);
    locked_d   = (state_d == ST_RUN);
    fail_d     = (state_d == ST_BYPASS);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      retries_q  <= '0;
      resetb_q   <= 1'b0;
      bypass_q   <= 1'b0;
      rstn_sys_q <= 1'b0;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retries_q  <= retries_d;
      resetb_q   <= resetb_d;
      bypass_q   <= bypass_d;
      rstn_sys_q <= rstn_sys_d;
      locked_q   <= locked_d;
      fail_q     <= fail_d;
    end
  end

  assign pll_resetb_o = resetb_q;
  assign pll_bypass_o = bypass_q;
  assign rstn_sys_o   = rstn_sys_q;
  assign locked_o     = locked_q;
  assign fail_o       = fail_q;
  assign retry_cnt_o  = retries_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_ice40_pll_seq_ctrl.sv
// Bench for ice40_pll_seq_ctrl: directed scenarios plus randomized lock/restart/reset
// traffic compared each cycle against a phase/timer reference model.
module tb_ice40_pll_seq_ctrl;

  localparam int RSTC = 16;
  localparam int TO   = 32;
  localparam int STB  = 64;
  localparam int MAXR = 2;

  localparam int P_RESET  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_BYPASS = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       lock;
  logic       restart;
  logic       pll_resetb, pll_bypass, rstn_sys, locked, fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int nvec = 0;
  int nbad = 0;

  // Reference model: phase, time spent in phase, timed-out attempts, sticky fail,
  // and the two-cycle delayed view of LOCK.
  int m_phase;
  int m_time;
  int m_tries;
  bit m_fail;
  bit lk_d1, lk_d2;

  always #5 clk = ~clk;

  ice40_pll_seq_ctrl #(
    .RST_CYCLES  (RSTC),
    .LOCK_TIMEOUT(TO),
    .LOCK_STABLE (STB),
    .MAX_RETRIES (MAXR)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .pll_lock_i  (lock),
    .restart_i   (restart),
    .pll_resetb_o(pll_resetb),
    .pll_bypass_o(pll_bypass),
    .rstn_sys_o  (rstn_sys),
    .locked_o    (locked),
    .fail_o      (fail),
    .retry_cnt_o (retry_cnt),
    .state_o     (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_RESET;
    m_time  = 0;
    m_tries = 0;
    m_fail  = 0;
    lk_d1   = 0;
    lk_d2   = 0;
  endtask

  task automatic model_step();
    bit seen;
    seen  = lk_d2;
    lk_d2 = lk_d1;
    lk_d1 = lock;
    if (restart) begin
      m_phase = P_RESET;
      m_time  = 0;
      m_tries = 0;
      m_fail  = 0;
    end else begin
      case (m_phase)
        P_RESET: begin
          m_time++;
          if (m_time >= RSTC) begin m_phase = P_WAIT; m_time = 0; end
        end
        P_WAIT: begin
          if (seen) begin
            m_phase = P_STABLE; m_time = 0;
          end else begin
            m_time++;
            if (m_time >= TO) begin
              m_tries = (m_tries < 15) ? m_tries + 1 : 15;
              m_time  = 0;
              if (m_tries >= MAXR) begin m_phase = P_BYPASS; m_fail = 1; end
              else m_phase = P_RESET;
            end
          end
        end
        P_STABLE: begin
          if (!seen) begin
            m_phase = P_WAIT; m_time = 0;
          end else begin
            m_time++;
            if (m_time >= STB) begin m_phase = P_RUN; m_tries = 0; m_time = 0; end
          end
        end
        P_RUN: begin
          if (!seen) begin m_phase = P_RESET; m_time = 0; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    bit e_resetb, e_sys;
    e_resetb = (m_phase == P_WAIT) || (m_phase == P_STABLE) || (m_phase == P_RUN);
    e_sys    = (m_phase == P_RUN) || (m_phase == P_BYPASS);
    chk({tag, ".state"},  32'(state),      32'(m_phase));
    chk({tag, ".retry"},  32'(retry_cnt),  32'(m_tries));
    chk({tag, ".resetb"}, 32'(pll_resetb), 32'(e_resetb));
    chk({tag, ".bypass"}, 32'(pll_bypass), 32'(m_phase == P_BYPASS));
    chk({tag, ".sysrst"}, 32'(rstn_sys),   32'(e_sys));
    chk({tag, ".locked"}, 32'(locked),     32'(m_phase == P_RUN));
    chk({tag, ".fail"},   32'(fail),       32'(m_fail));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (!rstn) model_reset();
    else model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic restart_pulse(input bit lock_val);
    restart = 1'b1;
    lock    = lock_val;
    tick("rstrt");
    restart = 1'b0;
  endtask

  initial begin
    int run_left;
    rstn    = 1'b0;
    lock    = 1'b1;
    restart = 1'b0;
    model_reset();
    #12;
    check_all("por");
    chk("por.state_const", 32'(state), 32'd0);

    // Power-up with LOCK constantly high.
    @(negedge clk);
    rstn = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      tick("up");
      if (e == 15) chk("up.resetb_e15", 32'(pll_resetb), 32'd0);
      if (e == 16) chk("up.resetb_e16", 32'(pll_resetb), 32'd1);
      if (e == 17) chk("up.stable_e17", 32'(state), 32'd2);
      if (e == 80) chk("up.locked_e80", 32'(locked), 32'd0);
      if (e == 81) chk("up.locked_e81", 32'(locked), 32'd1);
    end

    // Lock loss in RUN: outputs drop three edges later, then the sequence re-runs.
    lock = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick("loss");
      if (e == 2) chk("loss.locked_e2", 32'(locked), 32'd1);
      if (e == 3) chk("loss.locked_e3", 32'(locked), 32'd0);
    end
    lock = 1'b1;
    for (int e = 1; e <= 100; e++) tick("rerun");
    chk("rerun.locked", 32'(locked), 32'd1);

    // Glitch in STABLE at cnt 10.
    restart_pulse(1'b1);
    for (int i = 0; i < 300 && !(m_phase == P_STABLE && m_time == 10); i++) tick("toglitch");
    chk("glitch.reach_stable", 32'(state), 32'd2);
    lock = 1'b0;
    for (int i = 0; i < 3; i++) tick("glitch");
    lock = 1'b1;
    for (int i = 0; i < 120; i++) tick("glitch_rec");

    // Timeout path to BYPASS.
    restart_pulse(1'b0);
    for (int e = 1; e <= 100; e++) begin
      tick("tmo");
      if (e == 48) chk("tmo.retry_e48", 32'(retry_cnt), 32'd1);
      if (e == 96) chk("tmo.state_e96", 32'(state), 32'd4);
      if (e == 96) chk("tmo.bypass_e96", 32'(pll_bypass), 32'd1);
    end
    for (int i = 0; i < 30; i++) begin
      lock = 1'($urandom_range(0, 1));
      tick("byp_tog");
    end
    chk("byp.fail_hold", 32'(fail), 32'd1);
    restart_pulse(1'b1);
    chk("byp.restart_state", 32'(state), 32'd0);
    chk("byp.restart_fail", 32'(fail), 32'd0);
    for (int e = 1; e <= 81; e++) tick("byp_up");
    chk("byp.locked_e81", 32'(locked), 32'd1);

    // Async reset in the middle of WAIT.
    restart_pulse(1'b0);
    for (int i = 0; i < 20; i++) tick("towait");
    chk("arst.in_wait", 32'(state), 32'd1);
    @(posedge clk);
    model_step();
    #3;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    chk("arst.resetb_const", 32'(pll_resetb), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    lock = 1'b1;
    for (int e = 1; e <= 85; e++) tick("arst_up");
    chk("arst.locked", 32'(locked), 32'd1);

    // Randomized traffic: long LOCK runs, rare restarts and resets.
    run_left = 0;
    for (int c = 0; c < 2500; c++) begin
      if (run_left == 0) begin
        lock     = ($urandom_range(0, 3) != 0);
        run_left = $urandom_range(1, 90);
      end
      run_left--;
      restart = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 399) == 0) begin
        rstn = 1'b0;
        #1;
        model_reset();
        check_all("rnd_arst");
        tick("rnd_hold");
        rstn = 1'b1;
      end
      tick("rnd");
    end
    restart = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
